// File: rtl/psram_resp_pkg.sv
// Shared types and default constants for the PSRAM device-side responder.
package psram_resp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_LATN,
      ST_WDATA,
      ST_RDATA,
      ST_DONE
   } state_t;

   localparam logic [7:0] DEF_WCMD   = 8'hA0;
   localparam logic [7:0] DEF_RCMD   = 8'h20;
   localparam logic [7:0] DEF_RSTCMD = 8'hFF;
   localparam logic [3:0] DEF_WLC    = 4'd2;
   localparam logic [3:0] DEF_RLC    = 4'd5;

   // Edge counter: holds up to 2 * 15 latency edges.
   typedef logic [4:0] ecnt_t;

endpackage

// File: rtl/psram_resp_mem.sv
// Backing store for the responder: DEPTH x 8, synchronous write, asynchronous read.
module psram_resp_mem #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/psram_dev_resp.sv
// Octal-DDR PSRAM device-side responder. Oversamples psram_sck on clk_i, decodes
// opcode/address and serves burst writes and reads from an internal byte array.
// Optional build macro PSRAM_RESP_ADDR_CHK_EN: data-phase addresses >= DEPTH flag err_o,
// suppress writes and read back 8'h00; otherwise the array index simply wraps.
//
// state | meaning
// IDLE  | ce high, waiting for ce to fall
// CMD   | waiting for opcode on first rising edge, then its paired falling edge
// ADDR  | shifting in 4 address bytes, MSB first
// LATN  | counting latency edges; read tail drives dqs low
// WDATA | one byte per edge, written when dqs/dm = 1
// RDATA | one byte per edge driven on io, dqs toggles
// DONE  | ignoring edges until ce rises
module psram_dev_resp
   import psram_resp_pkg::*;
#(
   parameter int         DEPTH  = 1024,
   parameter logic [7:0] WCMD   = DEF_WCMD,
   parameter logic [7:0] RCMD   = DEF_RCMD,
   parameter logic [7:0] RSTCMD = DEF_RSTCMD,
   parameter logic [3:0] WLC    = DEF_WLC,
   parameter logic [3:0] RLC    = DEF_RLC
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       psram_sck_i,
   input  logic       psram_ce_i,
   input  logic [7:0] psram_io_in_i,
   output logic [7:0] psram_io_out_o,
   output logic       psram_io_en_o,
   input  logic       psram_dqs_in_i,
   output logic       psram_dqs_out_o,
   output logic       psram_dqs_en_o,
   output logic       busy_o,
   output logic       err_o
);

   localparam int    AW   = $clog2(DEPTH);
   localparam ecnt_t WLAT = {WLC, 1'b0};
   localparam ecnt_t RLAT = {RLC, 1'b0};

   state_t      state;
   logic        sck_q;
   logic        rise_q;
   logic        fall_q;
   logic        edge_q;
   logic        cmd_seen;
   logic [7:0]  opcode;
   ecnt_t       cnt;
   logic [31:0] addr;
   logic        addr_ok;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   // Edge flags are registered so sampling happens one clk_i after the sck transition.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sck_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sck_q  <= psram_sck_i;
         rise_q <= psram_sck_i & ~sck_q;
         fall_q <= ~psram_sck_i & sck_q;
      end
   end

   assign edge_q = rise_q | fall_q;

`ifdef PSRAM_RESP_ADDR_CHK_EN
   assign addr_ok = (addr < 32'(DEPTH));
`else
   assign addr_ok = 1'b1;
`endif

   assign mem_we = !psram_ce_i && (state == ST_WDATA) && edge_q && psram_dqs_in_i && addr_ok;

   psram_resp_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk_i),
      .we    (mem_we),
      .addr  (addr[AW-1:0]),
      .wdata (psram_io_in_i),
      .rdata (mem_rdata)
   );

   // Protocol FSM; ce high has priority over any pending sck edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state           <= ST_IDLE;
         cmd_seen        <= 1'b0;
         opcode          <= 8'h00;
         cnt             <= '0;
         addr            <= 32'h0;
         psram_io_out_o  <= 8'h00;
         psram_io_en_o   <= 1'b0;
         psram_dqs_out_o <= 1'b0;
         psram_dqs_en_o  <= 1'b0;
         busy_o          <= 1'b0;
         err_o           <= 1'b0;
      end else if (psram_ce_i) begin
         state           <= ST_IDLE;
         cmd_seen        <= 1'b0;
         psram_io_en_o   <= 1'b0;
         psram_dqs_en_o  <= 1'b0;
         psram_dqs_out_o <= 1'b0;
         busy_o          <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_CMD;
               cmd_seen <= 1'b0;
               busy_o   <= 1'b1;
            end
            ST_CMD: begin
               if (rise_q && !cmd_seen) begin
                  opcode <= psram_io_in_i;
                  if (psram_io_in_i == WCMD || psram_io_in_i == RCMD || psram_io_in_i == RSTCMD) begin
                     cmd_seen <= 1'b1;
                  end else begin
                     err_o <= 1'b1;
                     state <= ST_DONE;
                  end
               end else if (fall_q && cmd_seen) begin
                  state <= ST_ADDR;
                  cnt   <= ecnt_t'(4);
               end
            end
            ST_ADDR: begin
               if (edge_q) begin
                  addr <= {addr[23:0], psram_io_in_i};
                  cnt  <= cnt - ecnt_t'(1);
                  if (cnt == ecnt_t'(1)) begin
                     if (opcode == WCMD) begin
                        if (WLAT == '0) begin
                           state <= ST_WDATA;
                        end else begin
                           state <= ST_LATN;
                           cnt   <= WLAT;
                        end
                     end else if (opcode == RCMD) begin
                        if (RLAT == '0) begin
                           state           <= ST_RDATA;
                           psram_io_en_o   <= 1'b1;
                           psram_dqs_en_o  <= 1'b1;
                           psram_dqs_out_o <= 1'b0;
                        end else begin
                           state <= ST_LATN;
                           cnt   <= RLAT;
                        end
                     end else begin
                        state <= ST_DONE;
                     end
                  end
               end
            end
            ST_LATN: begin
               if (edge_q) begin
                  cnt <= cnt - ecnt_t'(1);
                  if (cnt == ecnt_t'(1)) begin
                     if (opcode == WCMD) begin
                        state <= ST_WDATA;
                     end else begin
                        state           <= ST_RDATA;
                        psram_io_en_o   <= 1'b1;
                        psram_dqs_en_o  <= 1'b1;
                        psram_dqs_out_o <= 1'b0;
                     end
                  end
               end
            end
            ST_WDATA: begin
               if (edge_q) begin
                  addr <= addr + 32'd1;
                  if (!addr_ok) err_o <= 1'b1;
               end
            end
            ST_RDATA: begin
               if (edge_q) begin
                  psram_io_out_o  <= addr_ok ? mem_rdata : 8'h00;
                  psram_dqs_out_o <= ~psram_dqs_out_o;
                  addr            <= addr + 32'd1;
                  if (!addr_ok) err_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
